// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan controller.
// Holds the conversion FSM state encoding, the segment code table
// (bit0 = a ... bit6 = g, active-high) and a constant helper for the clamp limit.
package seg7_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_REQ    = 2'd1,
      S_WAIT   = 2'd2,
      S_COMMIT = 2'd3
   } state_t;

   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;
   // Non-decimal codes light the middle bar only, so a bad digit is visible.
   localparam logic [6:0] SEG_BAD = 7'h40;

   // 10**n, evaluated at elaboration to size the clamp limit.
   function automatic logic [63:0] pow10(input int unsigned n);
      logic [63:0] r;
      r = 64'd1;
      for (int unsigned i = 0; i < n; i++) begin
         r = r * 64'd10;
      end
      return r;
   endfunction

endpackage

// File: rtl/seg7_dec.sv
// Combinational BCD digit to 7-segment decoder using the shared code table.
module seg7_dec
   import seg7_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   // Table lookup; codes 10-15 fall through to the middle-bar pattern.
   always_comb begin
      seg = SEG_BAD;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BAD;
      endcase
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment display controller.
// Periodically hands the binary input to an external BCD converter, collects
// the returned digits into a shadow set, commits them atomically to the display
// registers and scans the anodes one digit at a time with optional
// leading-zero blanking.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int BIN_VAL_WIDTH = 14,
   parameter int DEC_DIGITS    = 4,
   parameter int UPD_PERIOD    = 1000000,
   parameter int SCAN_PERIOD   = 50000,
   parameter int TIMEOUT       = 256
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en_i,
   input  logic                     blank_lz_i,
   input  logic [BIN_VAL_WIDTH-1:0] val_i,
   output logic                     bcd_req_o,
   output logic [BIN_VAL_WIDTH-1:0] bcd_val_o,
   input  logic [3:0]               bcd_digit_i,
   input  logic [DEC_DIGITS-1:0]    bcd_resp_i,
   output logic [6:0]               seg_o,
   output logic [DEC_DIGITS-1:0]    an_o,
   output logic                     busy_o,
   output logic                     ovf_o,
   output logic                     err_o
);

   localparam int UPD_W  = (UPD_PERIOD > 1) ? $clog2(UPD_PERIOD) : 1;
   localparam int SCAN_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
   localparam int IDX_W  = (DEC_DIGITS > 1) ? $clog2(DEC_DIGITS) : 1;
   localparam int TMO_W  = $clog2(TIMEOUT + 1);

   localparam logic [UPD_W-1:0]      UPD_LAST  = UPD_W'(UPD_PERIOD - 1);
   localparam logic [SCAN_W-1:0]     SCAN_LAST = SCAN_W'(SCAN_PERIOD - 1);
   localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(DEC_DIGITS - 1);
   localparam logic [TMO_W-1:0]      TMO_LAST  = TMO_W'(TIMEOUT - 1);
   localparam logic [DEC_DIGITS-1:0] AN_ONE    = DEC_DIGITS'(1);
   // Largest value the digit count can show; larger inputs are clamped to it.
   localparam logic [63:0]           MAX_VAL   = pow10(DEC_DIGITS) - 64'd1;

   state_t                        state_reg;
   state_t                        state_next;
   logic [UPD_W-1:0]              upd_cnt_reg;
   logic                          upd_tick;
   logic [TMO_W-1:0]              tmo_cnt_reg;
   logic                          tmo_hit;
   logic                          strobe_ok;
   logic                          last_strobe;
   logic                          load_val;
   logic                          shadow_we;
   logic                          commit;
   logic                          set_err;
   logic                          clamp;
   logic                          clamp_reg;
   logic [DEC_DIGITS-1:0][3:0]    shadow_reg;
   logic [DEC_DIGITS-1:0][3:0]    disp_reg;
   logic [DEC_DIGITS-1:0]         zero_above;
   logic [DEC_DIGITS-1:0]         blank;
   logic [SCAN_W-1:0]             scan_cnt_reg;
   logic                          scan_tick;
   logic [IDX_W-1:0]              idx_reg;
   logic [DEC_DIGITS-1:0]         an_sel;
   logic [6:0]                    seg_dec;

   assign upd_tick    = (upd_cnt_reg == UPD_LAST);
   assign tmo_hit     = (tmo_cnt_reg == TMO_LAST);
   // A multi-hot strobe is treated as corrupt and writes nothing.
   assign strobe_ok   = $onehot(bcd_resp_i);
   assign last_strobe = strobe_ok && bcd_resp_i[DEC_DIGITS-1];
   assign clamp       = (64'(val_i) > MAX_VAL);
   assign scan_tick   = (scan_cnt_reg == SCAN_LAST);
   assign an_sel      = AN_ONE << idx_reg;

   // Free-running update timebase; ticks once per period regardless of FSM state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         upd_cnt_reg <= '0;
      end else if (upd_tick) begin
         upd_cnt_reg <= '0;
      end else begin
         upd_cnt_reg <= upd_cnt_reg + UPD_W'(1);
      end
   end

   // Conversion FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state and control decode; ticks that arrive while busy are simply dropped.
   always_comb begin
      state_next = state_reg;
      load_val   = 1'b0;
      shadow_we  = 1'b0;
      commit     = 1'b0;
      set_err    = 1'b0;
      bcd_req_o  = 1'b0;
      busy_o     = 1'b1;
      case (state_reg)
         S_IDLE: begin
            busy_o = 1'b0;
            if (upd_tick && en_i) begin
               load_val   = 1'b1;
               state_next = S_REQ;
            end
         end
         S_REQ: begin
            bcd_req_o  = 1'b1;
            state_next = S_WAIT;
         end
         S_WAIT: begin
            shadow_we = strobe_ok;
            // A final strobe landing on the timeout cycle still counts as in time.
            if (last_strobe) begin
               state_next = S_COMMIT;
            end else if (tmo_hit) begin
               set_err    = 1'b1;
               state_next = S_IDLE;
            end
         end
         S_COMMIT: begin
            commit     = 1'b1;
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Cycles since the request; held at zero while idle, stops at the limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_reg <= '0;
      end else if (state_reg == S_IDLE) begin
         tmo_cnt_reg <= '0;
      end else if (!tmo_hit) begin
         tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
      end
   end

   // Operand and clamp flag captured as the request is issued, held until the next one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd_val_o <= '0;
         clamp_reg <= 1'b0;
      end else if (load_val) begin
         bcd_val_o <= clamp ? MAX_VAL[BIN_VAL_WIDTH-1:0] : val_i;
         clamp_reg <= clamp;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEC_DIGITS; gi++) begin : g_digit
         // Shadow digit: cleared at each new request so an abandoned conversion leaves nothing behind.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               shadow_reg[gi] <= 4'd0;
            end else if (load_val) begin
               shadow_reg[gi] <= 4'd0;
            end else if (shadow_we && bcd_resp_i[gi]) begin
               shadow_reg[gi] <= bcd_digit_i;
            end
         end

         // Display digit: only ever loaded from the shadow on commit.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               disp_reg[gi] <= 4'd0;
            end else if (commit) begin
               disp_reg[gi] <= shadow_reg[gi];
            end
         end

         // zero_above[k]: digit k and every more significant digit are zero.
         if (gi == DEC_DIGITS - 1) begin : g_top
            assign zero_above[gi] = (disp_reg[gi] == 4'd0);
         end else begin : g_low
            assign zero_above[gi] = (disp_reg[gi] == 4'd0) && zero_above[gi+1];
         end

         // The ones digit always shows so a zero value reads as "0".
         if (gi == 0) begin : g_ones
            assign blank[gi] = 1'b0;
         end else begin : g_upper
            assign blank[gi] = blank_lz_i && zero_above[gi];
         end
      end
   endgenerate

   // Committed error/overflow flags; err_o is sticky until reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_o <= 1'b0;
         err_o <= 1'b0;
      end else begin
         if (commit) begin
            ovf_o <= clamp_reg;
         end
         if (set_err) begin
            err_o <= 1'b1;
         end
      end
   end

   // Scan timebase: dwell SCAN_PERIOD cycles per digit, then move to the next one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt_reg <= '0;
         idx_reg      <= '0;
      end else if (scan_tick) begin
         scan_cnt_reg <= '0;
         idx_reg      <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
      end else begin
         scan_cnt_reg <= scan_cnt_reg + SCAN_W'(1);
      end
   end

   seg7_dec u_dec (
      .digit (disp_reg[idx_reg]),
      .seg   (seg_dec)
   );

   // Registered drive of the active digit; anode is dark when disabled or blanked.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_o <= '0;
         an_o  <= '0;
      end else begin
         seg_o <= seg_dec;
         an_o  <= (en_i && !blank[idx_reg]) ? an_sel : '0;
      end
   end

endmodule
